mmio_responder: RTL and testbench

- Memory-mapped I/O responder on the CPU data-memory bus, alongside Memoria; answers the memory interface from the memory side.
- Decodes a 64 KiB window and serves word-wide reads and writes to a timer/compare block and a transmit FIFO.
- The top level selects this block's Dataout over Memoria's whenever Hit is high.
- Read timing matches Memoria (one-cycle registered read), so the control unit's existing wait states need no change.

---
 rtl/mmio_responder.sv | 124 ++++++++++++
 tb/tb_mmio_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// Memory-mapped responder for a 64 KiB window on the data bus: free-running
// timer with compare interrupt plus a byte-wide transmit FIFO.
module mmio_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic        Wr,
    input  logic [31:0] Datain,
    output logic [31:0] Dataout,
    output logic        Hit,
    output logic [7:0]  TxData,
    output logic        TxValid,
    input  logic        TxReady,
    output logic        TimerIrq
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [13:0] W_COUNT  = 14'd0;
    localparam logic [13:0] W_CMP    = 14'd1;
    localparam logic [13:0] W_STATUS = 14'd2;
    localparam logic [13:0] W_TXDATA = 14'd3;
    localparam logic [13:0] W_CTRL   = 14'd4;

    logic [31:0]      count;
    logic [31:0]      cmp;
    logic [1:0]       ctrl;
    logic             irqPending;
    logic             overflow;
    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] fifoCount;

    logic [13:0] wordSel;
    logic        wrEn, wrCount, wrCmp, wrStatus, wrCtrl, pushReq, pushOk, pop;
    logic        fifoFull, fifoEmpty, match;
    logic [2:0]  countField;
    logic [31:0] readData;
    logic        unusedAddrBits;

    assign unusedAddrBits = ^Address[1:0];

    assign wordSel  = Address[15:2];
    assign Hit      = (Address[31:16] == BASE_ADDR[31:16]);
    assign wrEn     = Wr & Hit;
    assign wrCount  = wrEn & (wordSel == W_COUNT);
    assign wrCmp    = wrEn & (wordSel == W_CMP);
    assign wrStatus = wrEn & (wordSel == W_STATUS);
    assign pushReq  = wrEn & (wordSel == W_TXDATA);
    assign wrCtrl   = wrEn & (wordSel == W_CTRL);

    assign fifoFull  = (fifoCount == FULL_CNT);
    assign fifoEmpty = (fifoCount == '0);
    assign pop       = !fifoEmpty & TxReady;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pushOk    = pushReq & (!fifoFull | pop);
    assign match     = ctrl[0] & (count == cmp);

    assign TxData   = fifoMem[rdPtr];
    assign TxValid  = !fifoEmpty;
    assign TimerIrq = irqPending & ctrl[1];

    assign countField = 3'(fifoCount);

    always_comb begin
        readData = '0;
        case (wordSel)
            W_COUNT:  readData = count;
            W_CMP:    readData = cmp;
            W_STATUS: readData = {25'd0, countField, overflow, fifoEmpty, fifoFull, irqPending};
            W_CTRL:   readData = {30'd0, ctrl};
            default:  readData = '0;
        endcase
    end

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Dataout    <= '0;
            count      <= '0;
            cmp        <= '0;
            ctrl       <= '0;
            irqPending <= 1'b0;
            overflow   <= 1'b0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            fifoCount  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifoMem[i] <= '0;
        end else begin
            Dataout <= Hit ? readData : '0;

            if (wrCmp)  cmp  <= Datain;
            if (wrCtrl) ctrl <= Datain[1:0];

            if (wrCount)      count <= Datain;
            else if (match)   count <= '0;
            else if (ctrl[0]) count <= count + 32'd1;

            if (match)                      irqPending <= 1'b1;
            else if (wrStatus && Datain[0]) irqPending <= 1'b0;

            if (pushReq && !pushOk)         overflow <= 1'b1;
            else if (wrStatus && Datain[3]) overflow <= 1'b0;

            if (pushOk) begin
                fifoMem[wrPtr] <= Datain[7:0];
                wrPtr          <= nextPtr(wrPtr);
            end
            if (pop) rdPtr <= nextPtr(rdPtr);

            if (pushOk && !pop)      fifoCount <= fifoCount + 1'b1;
            else if (!pushOk && pop) fifoCount <= fifoCount - 1'b1;
        end
    end
endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed scenarios plus a randomized run against
// a queue-based reference model of the register map.
module tb_mmio_responder;
    localparam logic [31:0] BASE     = 32'hFFFF0000;
    localparam logic [31:0] A_COUNT  = BASE + 32'h00;
    localparam logic [31:0] A_CMP    = BASE + 32'h04;
    localparam logic [31:0] A_STATUS = BASE + 32'h08;
    localparam logic [31:0] A_TX     = BASE + 32'h0C;
    localparam logic [31:0] A_CTRL   = BASE + 32'h10;
    localparam int          DEPTH    = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Address;
    logic        Wr;
    logic [31:0] Datain;
    logic [31:0] Dataout;
    logic        Hit;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;
    logic        TimerIrq;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [31:0] mCount, mCmp, mDout;
    logic [1:0]  mCtrl;
    logic        mIrq, mOvf;
    logic [7:0]  mFifo[$];

    mmio_responder dut (
        .Clk(Clk), .Reset(Reset), .Address(Address), .Wr(Wr), .Datain(Datain),
        .Dataout(Dataout), .Hit(Hit), .TxData(TxData), .TxValid(TxValid),
        .TxReady(TxReady), .TimerIrq(TimerIrq)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic op(input logic [31:0] a, input logic w, input logic [31:0] d);
        Address = a;
        Wr      = w;
        Datain  = d;
        tick();
        Wr = 1'b0;
    endtask

    task automatic pulseReset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic modelReset();
        mCount = '0; mCmp = '0; mCtrl = '0; mIrq = 1'b0; mOvf = 1'b0; mDout = '0;
        mFifo.delete();
    endtask

    task automatic modelStep(input logic [31:0] a, input logic w, input logic [31:0] d, input logic rdy);
        logic        hit, wr, tmatch;
        int          off, n;
        logic [31:0] rv;
        hit = (a[31:16] == BASE[31:16]);
        off = int'(a[15:0]) & ~3;
        n   = mFifo.size();
        case (off)
            0:       rv = mCount;
            4:       rv = mCmp;
            8:       rv = 32'(mIrq) + 2 * 32'(n == DEPTH) + 4 * 32'(n == 0) + 8 * 32'(mOvf) + 16 * 32'(n);
            16:      rv = 32'(mCtrl);
            default: rv = 0;
        endcase
        mDout  = hit ? rv : 32'd0;
        wr     = w && hit;
        tmatch = mCtrl[0] && (mCount == mCmp);
        if (rdy && n > 0) void'(mFifo.pop_front());
        if (wr && off == 12) begin
            if (mFifo.size() < DEPTH) mFifo.push_back(d[7:0]);
            else mOvf = 1'b1;
        end
        if (wr && off == 8 && d[3]) mOvf = 1'b0;
        if (tmatch) mIrq = 1'b1;
        else if (wr && off == 8 && d[0]) mIrq = 1'b0;
        if (wr && off == 0) mCount = d;
        else if (tmatch) mCount = 0;
        else if (mCtrl[0]) mCount = mCount + 1;
        if (wr && off == 4)  mCmp = d;
        if (wr && off == 16) mCtrl = d[1:0];
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        Address = 32'h0; Wr = 1'b0; Datain = 32'h0; TxReady = 1'b0;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        vectors++;
        if (TxValid !== 1'b0 || TimerIrq !== 1'b0 || Dataout !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: TxValid=%b TimerIrq=%b Dataout=%h expected 0 0 0", TxValid, TimerIrq, Dataout);
        end
        for (int i = 0; i < 5; i++) begin
            op(BASE + 32'(4 * i), 1'b0, 32'h0);
            exp = (i == 2) ? 32'h4 : 32'h0;
            vectors++;
            if (Dataout !== exp) begin
                miscompares++;
                $display("FAIL reset_read[%0d]: Dataout=%h expected %h", i, Dataout, exp);
            end
        end
    endtask

    task automatic test_timer_irq();
        logic [31:0] exp;
        pulseReset();
        op(A_CMP, 1'b1, 32'd3);
        op(A_CTRL, 1'b1, 32'd3);
        for (int i = 0; i < 6; i++) begin
            Address = A_COUNT;
            tick();
            exp = (i < 4) ? 32'(i) : 32'(i - 4);
            vectors++;
            if (Dataout !== exp || TimerIrq !== (i >= 3)) begin
                miscompares++;
                $display("FAIL timer_seq[%0d]: count=%h irq=%b expected %h %b", i, Dataout, TimerIrq, exp, (i >= 3));
            end
        end
        op(A_STATUS, 1'b1, 32'h1);
        vectors++;
        if (TimerIrq !== 1'b0 || Dataout !== 32'h5) begin
            miscompares++;
            $display("FAIL irq_clear: irq=%b status=%h expected 0 00000005", TimerIrq, Dataout);
        end
        op(A_STATUS, 1'b1, 32'h1);
        vectors++;
        if (TimerIrq !== 1'b1 || Dataout !== 32'h4) begin
            miscompares++;
            $display("FAIL irq_set_wins: irq=%b status=%h expected 1 00000004", TimerIrq, Dataout);
        end
        op(A_CTRL, 1'b1, 32'h2);
        op(A_CTRL, 1'b1, 32'h0);
        op(A_STATUS, 1'b0, 32'h0);
        vectors++;
        if (TimerIrq !== 1'b0 || Dataout !== 32'h5) begin
            miscompares++;
            $display("FAIL irq_en_gate: irq=%b status=%h expected 0 00000005", TimerIrq, Dataout);
        end
    endtask

    task automatic test_fifo_overflow();
        pulseReset();
        TxReady = 1'b0;
        for (int b = 0; b < 5; b++) op(A_TX, 1'b1, 32'h41 + 32'(b));
        op(A_STATUS, 1'b0, 32'h0);
        vectors++;
        if (Dataout !== 32'h4A || TxValid !== 1'b1 || TxData !== 8'h41) begin
            miscompares++;
            $display("FAIL fifo_overflow: status=%h valid=%b data=%h expected 0000004a 1 41", Dataout, TxValid, TxData);
        end
        Address = 32'h0;
        TxReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (TxValid !== 1'b1 || TxData !== 8'(8'h41 + i)) begin
                miscompares++;
                $display("FAIL fifo_drain[%0d]: valid=%b data=%h expected 1 %h", i, TxValid, TxData, 8'(8'h41 + i));
            end
            tick();
        end
        TxReady = 1'b0;
        op(A_STATUS, 1'b0, 32'h0);
        vectors++;
        if (TxValid !== 1'b0 || Dataout !== 32'h0C) begin
            miscompares++;
            $display("FAIL fifo_empty: valid=%b status=%h expected 0 0000000c", TxValid, Dataout);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] expq[$];
        pulseReset();
        TxReady = 1'b0;
        for (int b = 0; b < 4; b++) op(A_TX, 1'b1, 32'h51 + 32'(b));
        vectors++;
        if (TxData !== 8'h51) begin
            miscompares++;
            $display("FAIL full_head: data=%h expected 51", TxData);
        end
        TxReady = 1'b1;
        op(A_TX, 1'b1, 32'h55);
        TxReady = 1'b0;
        op(A_STATUS, 1'b0, 32'h0);
        vectors++;
        if (Dataout !== 32'h42) begin
            miscompares++;
            $display("FAIL full_push_pop: status=%h expected 00000042", Dataout);
        end
        expq = '{8'h52, 8'h53, 8'h54, 8'h55};
        Address = 32'h0;
        TxReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (TxValid !== 1'b1 || TxData !== expq[i]) begin
                miscompares++;
                $display("FAIL full_drain[%0d]: valid=%b data=%h expected 1 %h", i, TxValid, TxData, expq[i]);
            end
            tick();
        end
        TxReady = 1'b0;
        vectors++;
        if (TxValid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_drain_end: valid=%b expected 0", TxValid);
        end
    endtask

    task automatic test_decode_wrap();
        logic [31:0] addrs[6];
        logic [31:0] exps[6];
        pulseReset();
        op(A_CMP, 1'b1, 32'd5);
        op(A_CMP, 1'b0, 32'h0);
        vectors++;
        if (Hit !== 1'b1 || Dataout !== 32'd5) begin
            miscompares++;
            $display("FAIL decode_hit: hit=%b data=%h expected 1 00000005", Hit, Dataout);
        end
        op(32'h0000_0100, 1'b0, 32'h0);
        vectors++;
        if (Hit !== 1'b0 || Dataout !== 32'h0) begin
            miscompares++;
            $display("FAIL decode_miss: hit=%b data=%h expected 0 00000000", Hit, Dataout);
        end
        op(BASE + 32'h20, 1'b1, 32'hDEADBEEF);
        addrs = '{BASE + 32'h20, BASE + 32'h06, A_COUNT, A_CTRL, A_STATUS, A_TX};
        exps  = '{32'h0, 32'd5, 32'h0, 32'h0, 32'h4, 32'h0};
        for (int i = 0; i < 6; i++) begin
            op(addrs[i], 1'b0, 32'h0);
            vectors++;
            if (Dataout !== exps[i]) begin
                miscompares++;
                $display("FAIL unmapped_write[%0d]: data=%h expected %h", i, Dataout, exps[i]);
            end
        end
        op(A_COUNT, 1'b1, 32'hFFFFFFFF);
        op(A_CTRL, 1'b1, 32'h1);
        exps[0] = 32'hFFFFFFFF; exps[1] = 32'h0; exps[2] = 32'h1;
        for (int i = 0; i < 3; i++) begin
            op(A_COUNT, 1'b0, 32'h0);
            vectors++;
            if (Dataout !== exps[i]) begin
                miscompares++;
                $display("FAIL count_wrap[%0d]: count=%h expected %h", i, Dataout, exps[i]);
            end
        end
        op(A_CTRL, 1'b1, 32'h0);
    endtask

    task automatic test_reset_midway();
        logic [31:0] exp;
        pulseReset();
        TxReady = 1'b0;
        op(A_CMP, 1'b1, 32'd2);
        op(A_TX, 1'b1, 32'hA1);
        op(A_TX, 1'b1, 32'hA2);
        op(A_CTRL, 1'b1, 32'h3);
        Address = A_COUNT;
        tick(); tick(); tick();
        vectors++;
        if (TimerIrq !== 1'b1 || TxValid !== 1'b1 || TxData !== 8'hA1) begin
            miscompares++;
            $display("FAIL pre_reset: irq=%b valid=%b data=%h expected 1 1 a1", TimerIrq, TxValid, TxData);
        end
        pulseReset();
        vectors++;
        if (TimerIrq !== 1'b0 || TxValid !== 1'b0 || Dataout !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset: irq=%b valid=%b data=%h expected 0 0 00000000", TimerIrq, TxValid, Dataout);
        end
        for (int i = 0; i < 5; i++) begin
            op(BASE + 32'(4 * i), 1'b0, 32'h0);
            exp = (i == 2) ? 32'h4 : 32'h0;
            vectors++;
            if (Dataout !== exp) begin
                miscompares++;
                $display("FAIL mid_reset_read[%0d]: data=%h expected %h", i, Dataout, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic        w, rdy, rst;
        int          word;
        pulseReset();
        modelReset();
        for (int it = 0; it < 600; it++) begin
            word = $urandom_range(0, 5);
            if ($urandom_range(0, 9) == 0) a = {16'h1234, 16'($urandom)};
            else a = BASE + 32'(4 * word) + 32'($urandom_range(0, 3));
            w   = ($urandom_range(0, 2) == 0);
            d   = (word <= 1) ? 32'($urandom_range(0, 6)) : $urandom;
            rdy = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 149) == 0);
            Address = a; Wr = w; Datain = d; TxReady = rdy; Reset = rst;
            #1;
            vectors++;
            if (Hit !== (a[31:16] == BASE[31:16])) begin
                miscompares++;
                $display("FAIL rand_hit[%0d]: hit=%b expected %b addr=%h", it, Hit, (a[31:16] == BASE[31:16]), a);
            end
            if (rst) modelReset();
            else modelStep(a, w, d, rdy);
            tick();
            Reset = 1'b0;
            Wr = 1'b0;
            vectors++;
            if (Dataout !== mDout) begin
                miscompares++;
                $display("FAIL rand_dout[%0d]: data=%h expected %h", it, Dataout, mDout);
            end
            vectors++;
            if (TxValid !== (mFifo.size() > 0) || TimerIrq !== (mIrq & mCtrl[1])) begin
                miscompares++;
                $display("FAIL rand_flags[%0d]: valid=%b irq=%b expected %b %b", it, TxValid, TimerIrq,
                         (mFifo.size() > 0), (mIrq & mCtrl[1]));
            end
            if (mFifo.size() > 0) begin
                vectors++;
                if (TxData !== mFifo[0]) begin
                    miscompares++;
                    $display("FAIL rand_txdata[%0d]: data=%h expected %h", it, TxData, mFifo[0]);
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b1; Address = 32'h0; Wr = 1'b0; Datain = 32'h0; TxReady = 1'b0;
        test_reset();
        test_timer_irq();
        test_fifo_overflow();
        test_back_to_back();
        test_decode_wrap();
        test_reset_midway();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
